// File: rtl/md_defs.sv
// Shared encodings and constants for the multiply/divide unit.
// Both the decode side and the stall logic import this package.
package md_defs;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  typedef enum logic {ST_IDLE, ST_RUN} md_state_e;

  localparam int MD_MULT_CYCLES = 5;
  localparam int MD_DIV_CYCLES  = 10;

  function automatic logic md_is_launch(md_op_e op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_datapath.sv
// Combinational product and quotient/remainder from the captured operands.
// The result is only sampled on the commit edge, so latency is set by the FSM counter.
module md_datapath
  import md_defs::*;
(
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        sgn;
  logic [63:0] ea, eb;
  logic [31:0] bd;
  logic signed [31:0] quot_s, rem_s;

  assign sgn = md_is_signed(op);

  // Low 64 bits of a 64x64 product of sign-extended operands give the signed result.
  assign ea   = sgn ? {{32{a[31]}}, a} : {32'b0, a};
  assign eb   = sgn ? {{32{b[31]}}, b} : {32'b0, b};
  assign prod = ea * eb;

  // A zero divisor is swapped for 1 so no X reaches the result; commit is suppressed anyway.
  assign div_zero = (b == 32'd0);
  assign bd       = div_zero ? 32'd1 : b;

  assign quot_s = $signed(a) / $signed(bd);
  assign rem_s  = $signed(a) % $signed(bd);

  assign quot = sgn ? $unsigned(quot_s) : (a / bd);
  assign rem  = sgn ? $unsigned(rem_s)  : (a % bd);

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: launch/run FSM, down-counter and HI/LO registers.
// md_stall covers both the launch cycle (start) and the busy window.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  md_op,
  input  logic        start,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        md_stall
);

  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  md_state_e   state;
  logic [CW-1:0] cnt;
  md_op_e      op_in, op_q;
  logic [31:0] a_q, b_q;
  logic [63:0] prod;
  logic [31:0] quot, rem;
  logic        div_zero;
  logic        launch;

  assign op_in    = md_op_e'(md_op);
  assign launch   = start && md_is_launch(op_in);
  assign md_stall = start | busy;

  md_datapath u_dp (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      HI    <= '0;
      LO    <= '0;
      op_q  <= MD_NONE;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (launch) begin
            state <= ST_RUN;
            busy  <= 1'b1;
            op_q  <= op_in;
            a_q   <= A;
            b_q   <= B;
            cnt   <= md_is_div(op_in) ? CW'(DIV_CYCLES - 1) : CW'(MULT_CYCLES - 1);
          end else if (!start && op_in == MD_MTHI) begin
            HI <= A;
          end else if (!start && op_in == MD_MTLO) begin
            LO <= A;
          end
        end
        ST_RUN: begin
          // start and mthi/mtlo are deliberately not looked at while running.
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            if (!md_is_div(op_q)) begin
              HI <= prod[63:32];
              LO <= prod[31:0];
            end else if (!div_zero) begin
              HI <= rem;
              LO <= quot;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/md_unit.md
# md_unit

Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It executes mult/multu/div/divu as multi-cycle operations and mthi/mtlo as single-cycle writes, and holds the HI/LO registers. It produces `md_stall`, the busy indication consumed by the D-stage stall logic. D-stage stalls on any MD-class instruction (mult…mflo) while `md_stall` is high. This unit is the producer of that stall request.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the `clk` rising edge.
- `A`  in  32  E-stage forwarded rs value (dividend, multiplicand, mthi/mtlo data).
- `B`  in  32  E-stage forwarded rt value (divisor, multiplier).
- `md_op`  in  3  operation select: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `start`  in  1  launch strobe for `md_op` 1–4; ignored for other ops.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.
- `busy`  out  1  registered; high while a mult/div is in flight.
- `md_stall`  out  1  combinational `start | busy`, routed to the D-stage stall logic.

## Operation
- FSM states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1, down-counter active.
- Transitions:
  - IDLE→RUN: on an edge with `start`=1 and `md_op`∈{1..4}. Operands and op are captured, and the counter is loaded with the cycle count minus 1.
  - RUN→RUN: while counter ≠ 0; the counter decrements each edge.
  - RUN→IDLE: on the edge where counter = 0. HI/LO are committed on this same edge.
- Arithmetic, on the captured operands:
  - mult: {HI,LO} = signed 32×32 → 64.
  - multu: {HI,LO} = unsigned 32×32 → 64.
  - div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero: the full DIV_CYCLES are still spent, and HI/LO are left unchanged.
- mthi/mtlo: when `md_op`=5/6 and the FSM is IDLE and `start`=0, HI (resp. LO) ← `A` on the edge.
- mthi/mtlo arriving while `busy`=1 or `start`=1 are ignored. The stall logic must prevent this case; the bench checks that it is ignored.
- `start` asserted while `busy`=1 is ignored, and the operation in flight completes unaffected.
- Operands on `A`/`B` may change freely after the launch edge.
- Reset (`reset`=0 on an edge) forces IDLE, `busy`=0, counter 0, HI=0, LO=0. Any in-flight result is discarded, including when reset lands on the commit edge.

## Timing
- Reset values: `HI`=0, `LO`=0, `busy`=0. `md_stall`=0 while `start`=0.
- Launch edge t: `busy`=1 for cycles t+1 … t+N, where N = MULT_CYCLES or DIV_CYCLES.
- At cycle t+N+1: `busy`=0 and the new HI/LO are visible.
- `md_stall` is high in cycle t (via `start`) and through cycles t+1 … t+N (via `busy`). There is no gap.
- mthi/mtlo: the new value is visible the cycle after the write edge.
- Back-to-back: a new `start` is accepted in the first cycle with `busy`=0.

## Structure
- Shared package `md_defs`:
  - `md_op` encodings `MD_NONE`, `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`.
  - Default cycle-count constants.
- The decoder and the stall logic import the same package.
- One sub-module is natural: `md_datapath`.
  - Combinational 64-bit product and quotient/remainder from captured operands and op.
  - Includes the divide-by-zero flag.
- FSM, counter and HI/LO registers stay in `md_unit`.

## Test plan
- Reset, then mult with A=0xFFFFFFFF, B=2, default parameters → `busy` high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
- multu with A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
- div with A=0xFFFFFFF9 (−7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Back-to-back: divu 7/2 immediately followed by `start` on the first idle cycle → first result LO=3, HI=1.
- Divide by zero: HI=0x1234, LO=0x5678 preloaded via mthi/mtlo, then div with A=5, B=0 → 10 busy cycles, and HI/LO remain 0x1234/0x5678.
- Illegal events during mult: mthi with A=0xAAAA during busy → ignored, final HI/LO equal the mult result. `reset` low at busy cycle 3 → HI=LO=0 and `busy`=0 next cycle, with no later commit.
